// File: rtl/lc3b_mem_pipe.sv
// Dual-port byte-lane block RAM for the LC-3b datapath: port 1 fetches, port 2 reads/writes.
// Each port has a request/valid handshake, an RD_LAT-deep response pipeline and a global stall.
module lc3b_mem_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  req1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic                  req2,
    input  logic [DATA_W/8-1:0]   we2,
    input  logic [ADDR_W-1:0]     addr2,
    input  logic [DATA_W-1:0]     data2_in,
    output logic [DATA_W-1:0]     data1_out,
    output logic                  valid1,
    output logic [DATA_W-1:0]     data2_out,
    output logic                  valid2
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned BW    = $clog2(NB);
    localparam int unsigned IW    = ADDR_W - BW;
    localparam int unsigned DEPTH = 2 ** IW;

    typedef logic [7:0] lane_t [DEPTH];

    // Power-up image: every word holds its own byte address.
    function automatic lane_t init_lane(input int unsigned lane);
        lane_t       img;
        logic [63:0] byte_addr;
        for (int unsigned w = 0; w < DEPTH; w++) begin
            byte_addr       = 64'(w) << BW;
            img[IW'(w)]     = 8'(byte_addr >> (8 * lane));
        end
        return img;
    endfunction

    logic [IW-1:0]     idx1;
    logic [IW-1:0]     idx2;
    logic [DATA_W-1:0] ram_q1;
    logic [DATA_W-1:0] ram_q2;
    logic [DATA_W-1:0] stage1_d1;
    logic [DATA_W-1:0] stage1_d2;
    logic [RD_LAT-1:0] vld1;
    logic [RD_LAT-1:0] vld2;
    logic              run;

    assign idx1 = addr1[ADDR_W-1:BW];
    assign idx2 = addr2[ADDR_W-1:BW];
    assign run  = !stall && !rst;

    if (BW > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^{addr1[BW-1:0], addr2[BW-1:0]};
    end

    // One RAM per byte lane; reads are read-first so colliding reads see the old word.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        lane_t      mem = init_lane(k);
        logic [7:0] q1;
        logic [7:0] q2;

        always_ff @(posedge clk) begin
            if (run) begin
                if (req2 && we2[k]) begin
                    mem[idx2] <= data2_in[8*k +: 8];
                end
                q1 <= mem[idx1];
                q2 <= mem[idx2];
            end
        end

        assign ram_q1[8*k +: 8] = q1;
        assign ram_q2[8*k +: 8] = q2;
    end

    // Stage 1 is the RAM output register, zeroed when it carries a bubble.
    assign stage1_d1 = vld1[0] ? ram_q1 : '0;
    assign stage1_d2 = vld2[0] ? ram_q2 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1 <= '0;
            vld2 <= '0;
        end else if (!stall) begin
            vld1[0] <= req1;
            vld2[0] <= req2;
            for (int i = 1; i < RD_LAT; i++) begin
                vld1[i] <= vld1[i-1];
                vld2[i] <= vld2[i-1];
            end
        end
    end

    assign valid1 = vld1[RD_LAT-1];
    assign valid2 = vld2[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
        assign data1_out = stage1_d1;
        assign data2_out = stage1_d2;
    end else begin : g_latn
        logic [DATA_W-1:0] pd1 [1:RD_LAT-1];
        logic [DATA_W-1:0] pd2 [1:RD_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 1; i < RD_LAT; i++) begin
                    pd1[i] <= '0;
                    pd2[i] <= '0;
                end
            end else if (!stall) begin
                pd1[1] <= stage1_d1;
                pd2[1] <= stage1_d2;
                for (int i = 2; i < RD_LAT; i++) begin
                    pd1[i] <= pd1[i-1];
                    pd2[i] <= pd2[i-1];
                end
            end
        end

        assign data1_out = pd1[RD_LAT-1];
        assign data2_out = pd2[RD_LAT-1];
    end

endmodule

// File: doc/lc3b_mem_pipe.md
Name: lc3b_mem_pipe

Overview:
- Parametrised dual-port synchronous block-RAM memory for the LC-3b datapath.
- Port 1 is read-only (instruction fetch). Port 2 is read/write with per-byte write enables (data access).
- Adds, per port: request/valid handshakes, a configurable read-latency pipeline, a global stall that freezes the pipeline, and byte-lane generalisation.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes; BW = log2(NB).
- ADDR_W, 16, byte-address width. Word index = addr[ADDR_W-1:BW]; low BW bits are ignored.
- RD_LAT, 1, read latency in cycles from accepted request to valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freezes the entire block while high.
- req1  in  1  port-1 read request.
- addr1  in  ADDR_W  port-1 byte address.
- req2  in  1  port-2 request (read, or write if any we2 bit is set).
- we2  in  NB  port-2 byte-lane write enables; bit k writes data2_in[8k+7:8k].
- addr2  in  ADDR_W  port-2 byte address.
- data2_in  in  DATA_W  port-2 write data.
- data1_out  out  DATA_W  port-1 read data; valid when valid1=1.
- valid1  out  1  port-1 response valid.
- data2_out  out  DATA_W  port-2 read data; valid when valid2=1.
- valid2  out  1  port-2 response valid (asserted for reads and writes).

Behaviour:
- Array: 2^(ADDR_W-BW) words stored as NB byte-lane arrays so the tool infers block RAM.
  - Initial content: word w = (w << BW) truncated to DATA_W, i.e. each word holds its own byte address.
  - rst does not alter array contents.
- Reset: valid1=0, valid2=0, data1_out=0, data2_out=0, all pipeline stage valids cleared. Takes effect immediately and asynchronously.
- Acceptance: a request on port p is accepted on a rising edge where req_p=1, stall=0 and rst=0. There is no back-pressure beyond stall.
- Array read: occurs in the acceptance cycle. Result enters stage 1; stages 2..RD_LAT are plain registers.
  - valid_p/data_p_out come from stage RD_LAT.
  - Accepted at edge N: valid_p=1 after edge N+RD_LAT-1 (RD_LAT=1 means valid in the cycle after acceptance).
- Full throughput: one request per port per cycle. Responses return in request order.
- When a stage carries no valid entry, its data is 0, so data_p_out=0 whenever valid_p=0.
- Writes:
  - Committed at the acceptance edge, only on lanes with we2[k]=1.
  - we2=0 with req2=1 is a pure read.
  - Port-2 write still produces a valid2 response carrying the pre-write word (read-first).
- Collisions, same word index in the same cycle:
  - Port-2 read-first: data2_out returns the old word.
  - Port 1 reading the word port 2 writes also returns the old word. The new data is visible to requests accepted from the next edge.
- Stall:
  - While stall=1: no acceptance, no writes, all pipeline stages and outputs hold their values (valid_p stays asserted if set).
  - Requests presented during stall are ignored, not queued. The requester must hold req.
- req_p=0 with stall=0: a bubble (valid=0, data=0) enters stage 1.
- Reset mid-operation: in-flight responses are discarded. A write committed on the edge before rst rose persists.
- Address wrap: the upper address bits select the word directly, so no wrap logic is needed. The full index space is implemented.

Test Plan:
- Reset/init, RD_LAT=1: assert rst, release, req1 with addr1=0x1234 -> cycle after acceptance valid1=1, data1_out=0x1234. Before release, valid1=valid2=0 and data outputs 0.
- Byte lanes: req2, we2=2'b01, addr2=0x0040, data2_in=0xBEEF; next cycle read addr2=0x0041 -> write response data2_out=0x0040. Read returns 0x00EF (odd address LSB ignored).
- Collision: same edge, port-2 write of 0xA5A5 (we2=2'b11) to 0x0100 and port-1 read of 0x0100 -> data1_out=0x0100, data2_out=0x0100. Next port-1 read of 0x0100 -> 0xA5A5.
- Latency/throughput, RD_LAT=3: back-to-back port-1 reads of 0x0002, 0x0004, 0x0006 -> valid1 high on three consecutive cycles starting 2 cycles after the first acceptance, with data 0x0002, 0x0004, 0x0006 in order.
- Stall, RD_LAT=2: stall for 3 cycles with a read in flight and a write presented -> outputs frozen, write to 0x0200 not performed (later read = 0x0200). After release the in-flight response emerges unchanged.
- Mid-flight reset, RD_LAT=4: rst pulse two cycles after a read is accepted -> valid1 never asserts for that request. Array contents are unchanged.
